// File: rtl/bandai_mapper_gen2_if.sv
// Console-side bus of the cartridge mapper plus the chip-select/address outputs toward ROM/RAM.
// Handshake: no valid/ready; a register write is the falling edge of WEn seen at a CLK edge (OEn high), a read is OEn low with WEn high.
interface bandai_mapper_gen2_if #(
  parameter int RADDR_W = 7
);
  logic               CEn;
  logic               SSn;
  logic               OEn;
  logic               WEn;
  logic [7:0]         ADDR;
  logic               SO;
  logic               ROMCEn;
  logic               RAMCEn;
  logic               RAMWEn;
  logic [RADDR_W-1:0] RADDR;

  modport master (
    output CEn, SSn, OEn, WEn, ADDR,
    input  SO, ROMCEn, RAMCEn, RAMWEn, RADDR
  );

  modport slave (
    input  CEn, SSn, OEn, WEn, ADDR,
    output SO, ROMCEn, RAMCEn, RAMWEn, RADDR
  );
endinterface

// File: rtl/bandai_mapper_gen2.sv
// Cartridge mapper: two-address key unlock with timeout, serial unlock bitstream, bank/LAO/CTRL
// registers and the window decoder that drives ROM/RAM chip selects and upper address lines.
module bandai_mapper_gen2 #(
  parameter int                NUM_ROM_BANKS = 2,
  parameter int                RADDR_W       = 7,
  parameter logic [7:0]        REG_BASE      = 8'hC0,
  parameter logic [7:0]        KEY0          = 8'h5A,
  parameter logic [7:0]        KEY1          = 8'hA5,
  parameter int                KEY_TIMEOUT   = 64,
  parameter int                BS_LEN        = 18,
  parameter logic [BS_LEN-1:0] BS_PATTERN    = 18'h05140
) (
  input  logic                 CLK,
  input  logic                 RST,
  bandai_mapper_gen2_if.slave  bus,
  inout  wire  [7:0]           DQ,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {
    K0       = 2'd0,
    K1       = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  localparam int NREG = 3 + NUM_ROM_BANKS;
  localparam int TW   = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
  localparam int CW   = $clog2(BS_LEN + 1);

  state_t             state;
  logic [TW-1:0]      timer;
  logic [BS_LEN-1:0]  shifter;
  logic [CW-1:0]      cnt;
  logic [7:0]         lao;
  logic [RADDR_W-1:0] ram_bank;
  logic [RADDR_W-1:0] rom_bank [NUM_ROM_BANKS];
  logic [6:0]         ctrl;
  logic               wen_q;

  logic               unlocked;
  logic [7:0]         idx;
  logic               reg_hit;
  logic               wr_commit;
  logic               rd_en;
  logic [7:0]         rd_data;
  logic [3:0]         w;
  logic               rce;
  logic               romce_n;
  logic               ramce_n;
  logic [RADDR_W-1:0] raddr;

  assign unlocked  = (state == UNLOCKED);
  assign idx       = bus.ADDR - REG_BASE;
  assign reg_hit   = unlocked & (~bus.CEn | ~bus.SSn) & (idx < 8'(NREG));
  assign wr_commit = reg_hit & wen_q & ~bus.WEn & bus.OEn;
  assign rd_en     = reg_hit & ~bus.OEn & bus.WEn;
  assign dbg_state = state;

  always_comb begin
    rd_data = '0;
    if (idx == 8'd0) begin
      rd_data = lao;
    end else if (idx == 8'd1) begin
      rd_data = 8'(ram_bank);
    end else if (idx == 8'(NREG - 1)) begin
      rd_data = {1'b0, ctrl};
    end else begin
      for (int i = 0; i < NUM_ROM_BANKS; i++) begin
        if (idx == 8'(i + 2)) rd_data = 8'(rom_bank[i]);
      end
    end
  end

  // Windows above the last ROM bank map linearly: window index on top, LAO supplies the low bits.
  always_comb begin
    w       = bus.ADDR[7:4];
    rce     = unlocked & bus.SSn & ~bus.CEn;
    romce_n = 1'b1;
    ramce_n = 1'b1;
    raddr   = '0;
    if (rce && (w != 4'd0)) begin
      if (w == 4'd1) begin
        ramce_n = 1'b0;
        raddr   = ram_bank;
      end else if (int'(w) <= 1 + NUM_ROM_BANKS) begin
        romce_n = 1'b0;
        for (int i = 0; i < NUM_ROM_BANKS; i++) begin
          if (int'(w) == i + 2) raddr = rom_bank[i];
        end
      end else begin
        romce_n = 1'b0;
        raddr   = {w, lao[RADDR_W-5:0]};
      end
    end
  end

  assign bus.ROMCEn = romce_n;
  assign bus.RAMCEn = ramce_n;
  assign bus.RAMWEn = bus.WEn | ramce_n | ctrl[0];
  assign bus.RADDR  = raddr;
  assign bus.SO     = shifter[0];
  assign DQ         = rd_en ? rd_data : 8'hzz;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= K0;
      timer    <= '0;
      shifter  <= '1;
      cnt      <= '0;
      lao      <= '1;
      ram_bank <= '1;
      for (int i = 0; i < NUM_ROM_BANKS; i++) rom_bank[i] <= '1;
      ctrl     <= '0;
      wen_q    <= 1'b1;
    end else begin
      wen_q <= bus.WEn;
      // The shift keeps running through a relock; only a fresh unlock reloads it.
      if (cnt != '0) begin
        shifter <= {1'b1, shifter[BS_LEN-1:1]};
        cnt     <= cnt - 1'b1;
      end
      case (state)
        K0: begin
          if (bus.ADDR == KEY0) begin
            state <= K1;
            timer <= '0;
          end
        end
        K1: begin
          if (bus.ADDR == KEY1) begin
            state   <= UNLOCKED;
            shifter <= BS_PATTERN;
            cnt     <= CW'(BS_LEN);
          end else if (bus.ADDR == KEY0) begin
            timer <= '0;
          end else if ((KEY_TIMEOUT != 0) && (timer == TW'(KEY_TIMEOUT - 1))) begin
            state <= K0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        UNLOCKED: begin
          if (wr_commit && (idx == 8'(NREG - 1)) && DQ[7]) state <= K0;
        end
        default: state <= K0;
      endcase
      if (wr_commit) begin
        if (idx == 8'd0) begin
          lao <= DQ;
        end else if (idx == 8'd1) begin
          ram_bank <= DQ[RADDR_W-1:0];
        end else if (idx == 8'(NREG - 1)) begin
          ctrl <= DQ[6:0];
        end else begin
          for (int i = 0; i < NUM_ROM_BANKS; i++) begin
            if (idx == 8'(i + 2)) rom_bank[i] <= DQ[RADDR_W-1:0];
          end
        end
      end
    end
  end
endmodule
